// File: rtl/fetch_stage_if.sv
// Bus bundle for fetch_stage: instruction-memory read port, decode
// handshake and execute/decode control inputs (redirect, halt).
interface fetch_stage_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    modport master (
        output imem_ren, imem_addr, fetch_valid, instr, pc, pc_plus4,
        input  imem_ready, imem_rdata, fetch_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_ren, imem_addr, fetch_valid, instr, pc, pc_plus4,
        output imem_ready, imem_rdata, fetch_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, one outstanding imem read, 2-entry
// {pc, instr} queue to decode. Define FETCH_PERF_EN for perf counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] drain_addr_reg, drain_addr_next;
    logic [1:0]  count_reg, count_next;

    // Shift queue: entry 0 is always the head, so the decode outputs are
    // straight register reads.
    logic [31:0] q_pc_reg    [2];
    logic [31:0] q_pc_next   [2];
    logic [31:0] q_instr_reg [2];
    logic [31:0] q_instr_next[2];

    logic ren_int;
    logic pending;
    logic pop;
    logic push;
    logic take_redirect;
    logic take_halt;

    always_comb begin
        ren_int = 1'b0;
        case (state_reg)
            ST_RUN:   ren_int = (count_reg < 2'd2);
            ST_DRAIN: ren_int = 1'b1;
            default:  ren_int = 1'b0;
        endcase
    end

    assign bus.imem_ren    = ren_int & ~RST;
    assign bus.imem_addr   = (state_reg == ST_DRAIN) ? drain_addr_reg : fetch_pc_reg;
    assign bus.fetch_valid = (count_reg != 2'd0);
    assign bus.instr       = q_instr_reg[0];
    assign bus.pc          = q_pc_reg[0];
    assign bus.pc_plus4    = q_pc_reg[0] + 32'd4;

    assign pop           = bus.fetch_valid & bus.fetch_ready;
    assign pending       = ren_int & ~bus.imem_ready;
    assign take_redirect = bus.redirect & (state_reg != ST_HALTED);
    // A same-cycle redirect comes from an older instruction and wins over halt.
    assign take_halt     = bus.halt & pop & (state_reg == ST_RUN) & ~bus.redirect;
    assign push          = (state_reg == ST_RUN) & ren_int & bus.imem_ready
                           & ~bus.redirect & ~take_halt;

    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        drain_addr_next = drain_addr_reg;
        count_next      = count_reg;
        q_pc_next       = q_pc_reg;
        q_instr_next    = q_instr_reg;

        if (take_redirect) begin
            count_next    = 2'd0;
            fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
            if (pending) begin
                // The in-flight read cannot be withdrawn; wait it out and drop it.
                state_next      = ST_DRAIN;
                drain_addr_next = bus.imem_addr;
            end else begin
                state_next = ST_RUN;
            end
        end else if (state_reg == ST_DRAIN) begin
            if (bus.imem_ready) begin
                state_next = ST_RUN;
            end
        end else if (take_halt) begin
            count_next = 2'd0;
            state_next = ST_HALTED;
        end else if (state_reg == ST_RUN) begin
            if (push) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            case ({push, pop})
                2'b11: begin
                    // Push implies count < 2 and pop implies count > 0: count is 1.
                    q_pc_next[0]    = fetch_pc_reg;
                    q_instr_next[0] = bus.imem_rdata;
                end
                2'b01: begin
                    q_pc_next[0]    = q_pc_reg[1];
                    q_instr_next[0] = q_instr_reg[1];
                    count_next      = count_reg - 2'd1;
                end
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        q_pc_next[0]    = fetch_pc_reg;
                        q_instr_next[0] = bus.imem_rdata;
                    end else begin
                        q_pc_next[1]    = fetch_pc_reg;
                        q_instr_next[1] = bus.imem_rdata;
                    end
                    count_next = count_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_RUN;
            fetch_pc_reg   <= RESET_PC;
            drain_addr_reg <= RESET_PC;
            count_reg      <= 2'd0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            drain_addr_reg <= drain_addr_next;
            count_reg      <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (RST) begin
                    q_pc_reg[gi]    <= '0;
                    q_instr_reg[gi] <= '0;
                end else begin
                    q_pc_reg[gi]    <= q_pc_next[gi];
                    q_instr_reg[gi] <= q_instr_next[gi];
                end
            end
        end
    endgenerate

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (pop) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (bus.fetch_valid && !bus.fetch_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule
